// File: rtl/gpio_cond_pkg.sv
// Shared defaults and helpers for the GPIO input conditioner.
// Board tops reuse these constants so every instance agrees on timing.
package gpio_cond_pkg;

    localparam int DEF_WIDTH           = 5;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

    // The counter only ever needs to hold DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Bundle of per-pin conditioner signals.
// The master side drives pads and controls; the slave side conditions them.
interface gpio_input_conditioner_if #(
    parameter int WIDTH = gpio_cond_pkg::DEF_WIDTH
);

    logic [WIDTH-1:0] pins_in;
    logic [WIDTH-1:0] bypass;
    logic [WIDTH-1:0] flag_clear;
    logic [WIDTH-1:0] pins_read;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_flag;

    modport master (
        output pins_in, bypass, flag_clear,
        input  pins_read, rise, fall, edge_flag
    );

    modport slave (
        input  pins_in, bypass, flag_clear,
        output pins_read, rise, fall, edge_flag
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: synchronizer chain, debounce counter, edge pulses and sticky flag.
// The accepted level only moves after DEBOUNCE_CYCLES consecutive differing samples.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gpio_input_conditioner_if.slave bus
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;
    logic                   stable;
    logic                   stable_prev;
    logic                   stable_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   rise;
    logic                   fall;
    logic                   edge_flag;
    edge_t                  evt;

    assign sync = sync_chain[SYNC_STAGES-1];

    // Bypass forces the count to zero, so leaving bypass always restarts from scratch.
    always_comb begin
        stable_next = stable;
        count_next  = '0;
        if (bus.bypass[0]) begin
            stable_next = sync;
        end else if (sync != stable) begin
            if (count == CNT_MAX) begin
                stable_next = sync;
            end else begin
                count_next = count + 1'b1;
            end
        end
    end

    always_comb begin
        evt = EDGE_NONE;
        if (stable && !stable_prev) begin
            evt = EDGE_RISE;
        end else if (!stable && stable_prev) begin
            evt = EDGE_FALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain  <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            count       <= '0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            edge_flag   <= 1'b0;
        end else begin
            sync_chain  <= {sync_chain[SYNC_STAGES-2:0], bus.pins_in[0]};
            stable      <= stable_next;
            stable_prev <= stable;
            count       <= count_next;
            rise        <= (evt == EDGE_RISE);
            fall        <= (evt == EDGE_FALL);
            // A new edge outranks a clear arriving in the same cycle.
            if (evt != EDGE_NONE) begin
                edge_flag <= 1'b1;
            end else if (bus.flag_clear[0]) begin
                edge_flag <= 1'b0;
            end
        end
    end

    assign bus.pins_read[0] = stable;
    assign bus.rise[0]      = rise;
    assign bus.fall[0]      = fall;
    assign bus.edge_flag[0] = edge_flag;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions WIDTH asynchronous pad inputs into clean levels and edge events.
// Each pin is an independent gpio_debounce_bit; nothing is shared across pins.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             io_sys_clock,
    input  logic             io_sys_reset,
    input  logic [WIDTH-1:0] io_pins_in,
    input  logic [WIDTH-1:0] io_bypass,
    input  logic [WIDTH-1:0] io_flagClear,
    output logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic [WIDTH-1:0] io_edgeFlag
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_input_conditioner_if #(.WIDTH(1)) pin_bus ();

        assign pin_bus.pins_in    = io_pins_in[i];
        assign pin_bus.bypass     = io_bypass[i];
        assign pin_bus.flag_clear = io_flagClear[i];
        assign io_pins_read[i]    = pin_bus.pins_read[0];
        assign io_rise[i]         = pin_bus.rise[0];
        assign io_fall[i]         = pin_bus.fall[0];
        assign io_edgeFlag[i]     = pin_bus.edge_flag[0];

        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (io_sys_clock),
            .rst_n (io_sys_reset),
            .bus   (pin_bus.slave)
        );
    end

endmodule
